// File: rtl/mem_pkg.sv
// Shared encodings for the data_mem_ctrl load/store sequencer and its data_memory port.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic MEM_SZ_BYTE = 1'b0;
    localparam logic MEM_SZ_WORD = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1,
        S_RESP
    } state_t;

    // Misaligned word/half or the reserved size code.
    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_bad = 1'b0;
            SZ_HALF: is_bad = addr_lo[0];
            SZ_WORD: is_bad = (addr_lo != 2'b00);
            default: is_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align_ext.sv
// Sign/zero extension of the raw load capture into the response data word.
module load_align_ext
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = '0;
        case (size)
            SZ_BYTE: data = sgn ? {{(DATA_W-8){raw[7]}}, raw[7:0]} : DATA_W'(raw[7:0]);
            SZ_HALF: data = sgn ? {{(DATA_W-16){raw[15]}}, raw[15:0]} : DATA_W'(raw[15:0]);
            SZ_WORD: data = raw;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer driving data_memory; halfwords are split into two byte beats.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_DI,
    output logic              mem_Size,
    output logic              mem_RW,
    output logic              mem_E,
    input  logic [DATA_W-1:0] mem_DO
);

    state_t            state, state_n;
    logic              rw_q, signed_q, err_q, size_hold_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q, a_hold_q;
    logic [DATA_W-1:0] wdata_q, raw_q, ext_data;
    logic              beat0, beat1;

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_n = is_bad(req_size, req_addr[1:0]) ? S_RESP : S_BEAT0;
            end
            S_BEAT0: state_n = (size_q == SZ_HALF) ? S_BEAT1 : S_RESP;
            S_BEAT1: state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign beat0 = (state == S_BEAT0);
    assign beat1 = (state == S_BEAT1);

    // Pins outside the beats fall back to the last driven address/size.
    always_comb begin
        mem_A    = a_hold_q;
        mem_Size = size_hold_q;
        mem_DI   = '0;
        mem_RW   = (beat0 || beat1) && rw_q;
        mem_E    = (beat0 || beat1) && rw_q;
        if (beat0) begin
            mem_A    = addr_q;
            mem_Size = (size_q == SZ_WORD) ? MEM_SZ_WORD : MEM_SZ_BYTE;
            if (rw_q) begin
                case (size_q)
                    SZ_WORD: mem_DI = wdata_q;
                    SZ_HALF: mem_DI = DATA_W'(wdata_q[15:8]);
                    default: mem_DI = DATA_W'(wdata_q[7:0]);
                endcase
            end
        end else if (beat1) begin
            mem_A    = addr_q + ADDR_W'(1);
            mem_Size = MEM_SZ_BYTE;
            if (rw_q)
                mem_DI = DATA_W'(wdata_q[7:0]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rw_q        <= 1'b0;
            signed_q    <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= SZ_BYTE;
            addr_q      <= '0;
            wdata_q     <= '0;
            raw_q       <= '0;
            a_hold_q    <= '0;
            size_hold_q <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        rw_q     <= req_rw;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        err_q    <= is_bad(req_size, req_addr[1:0]);
                        raw_q    <= '0;
                    end
                end
                S_BEAT0: begin
                    a_hold_q    <= mem_A;
                    size_hold_q <= mem_Size;
                    if (!rw_q)
                        raw_q <= (size_q == SZ_WORD) ? mem_DO : DATA_W'(mem_DO[7:0]);
                end
                S_BEAT1: begin
                    a_hold_q    <= mem_A;
                    size_hold_q <= mem_Size;
                    // First beat supplied the high byte (big-endian half).
                    if (!rw_q)
                        raw_q <= DATA_W'({raw_q[7:0], mem_DO[7:0]});
                end
                default: ;
            endcase
        end
    end

    load_align_ext #(.DATA_W(DATA_W)) u_ext (
        .size (size_q),
        .sgn  (signed_q),
        .raw  (raw_q),
        .data (ext_data)
    );

    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !rw_q && !err_q) ? ext_data : '0;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store sequencer that acts as the initiator for `data_memory`. It takes one CPU load/store request at a time over a valid/ready handshake, supports byte, halfword and word accesses, and drives `data_memory`'s A/DI/Size/RW/E pins. It returns sign- or zero-extended load data on a one-cycle response pulse. Halfwords are built from two byte beats, because `data_memory` only supports byte and word. It sits between the execute/memory pipeline stage and `data_memory`.

## Interface
- `ADDR_W`, 8: byte address width; must match `data_memory`.
- `DATA_W`, 32: data width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_rw` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as error).
- `req_signed` in 1: sign-extend byte/halfword loads.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, right-justified.
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_rdata` out DATA_W: load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned or reserved size.
- `mem_A` out ADDR_W, `mem_DI` out DATA_W, `mem_Size` out 1, `mem_RW` out 1, `mem_E` out 1: to `data_memory`.
- `mem_DO` in DATA_W: from `data_memory`; combinational read.

## Operation
- Memory is big-endian: a word at A is {mem[A], mem[A+1], mem[A+2], mem[A+3]}. A byte read returns {24'b0, mem[A]}.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - `req_ready`=1.
  - On handshake, latch all `req_*` fields.
  - If misaligned (word with addr[1:0]≠0, half with addr[0]≠0) or size 11, go to RESP with err=1. Otherwise go to BEAT0.
- BEAT0:
  - Drive `mem_A`=addr and `mem_RW`=rw.
  - `mem_Size`=1 for word, 0 otherwise.
  - Store data on `mem_DI`: word → wdata; byte → {24'b0, wdata[7:0]}; half → {24'b0, wdata[15:8]}.
  - `mem_E`=rw (store only).
  - Loads capture `mem_DO` at the closing edge: word takes all 32 bits, byte/half takes [7:0].
  - Half goes to BEAT1; everything else goes to RESP.
- BEAT1 (half only):
  - `mem_A`=addr+1, `mem_Size`=0.
  - Stores drive `mem_DI`={24'b0, wdata[7:0]}.
  - Loads capture `mem_DO[7:0]` as the low byte.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1.
  - Byte loads are extended from bit 7, half loads from bit 15. `req_signed` is ignored for words and stores.
  - Go to IDLE.
- In IDLE and RESP: `mem_E`=0 and `mem_RW`=0; `mem_A`/`mem_Size` hold their last values; `mem_DI`=0.
- Aligned halfwords never cross 0xFF, so no address wrap is possible. addr+1 is ADDR_W-bit modular.
- Errored requests never assert `mem_E` or touch the memory pins beyond the IDLE values.

## Timing
- Handshake at edge T. The first timing point refers to the BEAT0 cycle, the remaining points to the RESP (`rsp_valid`) cycle:
  - Byte/word: BEAT0 during cycle T→T+1; `rsp_valid` during T+1→T+2.
  - Half: `rsp_valid` one cycle later.
  - Error: `rsp_valid` during T→T+1.
- `mem_E` is high for exactly one cycle per store beat. A/DI/Size/RW are stable for that whole cycle.
- `req_ready` is low from BEAT0 through RESP. Maximum throughput is one byte/word request per 3 cycles.
- `mem_*` are decoded from the state and latched registers only. No `req_*` input reaches a `mem_*` pin combinationally.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, all `mem_*`=0.
- Reset mid-operation: all outputs go to their reset values immediately, asynchronously. A half store interrupted in BEAT1 leaves mem[addr] written and mem[addr+1] unchanged; there is no rollback. No response is issued for the aborted request.

## Structure
- Shared package `mem_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, and the `data_memory` Size encoding (0 byte, 1 word).
- One sub-module, `load_align_ext`: combinational extension from (size, signed, raw 32-bit capture) to `rsp_rdata`.
- FSM and beat registers live in `data_mem_ctrl`.

## Test plan
- Reset, store word 0xABCDEF01 @8, then load word @8:
  - `mem_E` is high exactly one cycle.
  - The load response arrives at T+2 with `rsp_rdata`=ABCDEF01.
  - A byte load @9 returns 000000CD.
- Store byte 0xA6 @0:
  - Signed byte load @0 returns FFFFFFA6.
  - Unsigned byte load @0 returns 000000A6.
- Store half 0x8123 @2:
  - Two E pulses, at A=2 then A=3.
  - Signed half load @2 returns FFFF8123 at T+3.
  - Unsigned half load @2 returns 00008123.
- Word load @6, half load @5, size 11 @0:
  - Each gives `rsp_err`=1 and `rsp_rdata`=0 at T+1.
  - `mem_E` never rises.
- Store half 0xBEEF @4 over prior zeros, with `reset` asserted during BEAT1:
  - `mem_E` drops the same cycle.
  - No `rsp_valid`.
  - After reset, a word load @4 returns BE000000.
- `req_valid` held high with three back-to-back requests:
  - `req_ready` is low in BEAT0/BEAT1/RESP.
  - Each request is accepted exactly once, in order, with no drops or duplicate responses.
